// File: rtl/keyboard_pkg.sv
// keyboard_pkg: shared constants for the keyboard action controller.
//   - action indices inside a player's 6-bit action group
//   - global enter/pause scan codes
//   - default two-player KEY_MAP (entry p*6+a lives at bits [9*(p*6+a)+:9])
//   - repeat FSM state encoding, exposed on debug outputs
package keyboard_pkg;

    localparam int ACTIONS_PER_PLAYER = 6;

    localparam int ACT_LEFT   = 0;
    localparam int ACT_RIGHT  = 1;
    localparam int ACT_ROTATE = 2;
    localparam int ACT_CHANGE = 3;
    localparam int ACT_SPEED  = 4;
    localparam int ACT_DROP   = 5;

    localparam logic [8:0] CODE_ENTER = 9'h05A;
    localparam logic [8:0] CODE_PAUSE = 9'h04D;

    // Entry 0 (P1 left) sits in the least significant 9 bits.
    localparam logic [9*ACTIONS_PER_PLAYER*2-1:0] DEFAULT_KEY_MAP = {
        9'h029, 9'h072, 9'h049, 9'h073, 9'h07A, 9'h069,  // P2: Space 2 > 5 3 1
        9'h012, 9'h023, 9'h01A, 9'h024, 9'h02B, 9'h01B   // P1: LShift D Z E F S
    };

    // RPT_HELD is the single "key down" state used when auto-repeat is
    // compiled out; RPT_DELAY/RPT_REPEAT are used only with auto-repeat.
    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2,
        RPT_HELD   = 2'd3
    } rpt_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_repeat_fsm.sv
// key_repeat_fsm: one repeating action (left, right or speed).
// Samples the action key and an optional blocking key, detects the press
// and, when KEY_AUTOREPEAT_EN is defined, auto-repeats while held.
// Without KEY_AUTOREPEAT_EN the action is edge-only and has no counter.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   key_level    - raw key level (already gated by player enable)
//   block_level  - raw level of a key that suppresses this action (0 if none)
//   enable       - player enable; 0 forces the FSM to IDLE immediately
//   pulse        - registered one-cycle action pulse
//   state_dbg    - current FSM state
module key_repeat_fsm
    import keyboard_pkg::*;
#(
    parameter int REPEAT_DELAY  = 10_000_000,
    parameter int REPEAT_PERIOD = 2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_level,
    input  logic       block_level,
    input  logic       enable,
    output logic       pulse,
    output rpt_state_t state_dbg
);

    logic       key_smp;
    logic       block_smp;
    logic       held;
    logic       pulse_nxt;
    rpt_state_t state, state_nxt;

    // Leaving any active state always goes through a cycle with held=0,
    // so "IDLE and held" is exactly a fresh press.
    assign held      = key_smp & ~block_smp & enable;
    assign state_dbg = state;

`ifdef KEY_AUTOREPEAT_EN
    localparam int CNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] count, count_nxt;

    always_comb begin
        state_nxt = state;
        count_nxt = '0;
        pulse_nxt = 1'b0;
        unique case (state)
            RPT_IDLE: begin
                if (held) begin
                    state_nxt = RPT_DELAY;
                    pulse_nxt = 1'b1;
                end
            end
            RPT_DELAY, RPT_REPEAT: begin
                if (!held) begin
                    state_nxt = RPT_IDLE;
                end else if ((state == RPT_DELAY && count == DELAY_LAST) ||
                             (state == RPT_REPEAT && count == PERIOD_LAST)) begin
                    state_nxt = RPT_REPEAT;
                    pulse_nxt = 1'b1;
                end else if (count != '1) begin
                    count_nxt = count + 1'b1;  // saturate, never wrap
                end else begin
                    count_nxt = count;
                end
            end
            default: state_nxt = RPT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end
`else
    always_comb begin
        state_nxt = state;
        pulse_nxt = 1'b0;
        unique case (state)
            RPT_IDLE: begin
                if (held) begin
                    state_nxt = RPT_HELD;
                    pulse_nxt = 1'b1;
                end
            end
            default: begin
                if (!held) state_nxt = RPT_IDLE;
            end
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            key_smp   <= 1'b0;
            block_smp <= 1'b0;
            state     <= RPT_IDLE;
            pulse     <= 1'b0;
        end else begin
            key_smp   <= key_level;
            block_smp <= block_level;
            state     <= state_nxt;
            pulse     <= pulse_nxt;
        end
    end

endmodule

// File: rtl/keyboard_action_ctrl.sv
// keyboard_action_ctrl: turns held-key levels into one-cycle game action
// pulses for up to four players plus global enter/pause pulses.
// Left/right/speed use key_repeat_fsm (auto-repeat when KEY_AUTOREPEAT_EN
// is defined, edge-only otherwise); rotate/change/drop/enter/pause are
// always edge-only. Press pulses appear two clk edges after a key rise.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   key_down[511:0]   - held-key levels indexed by 9-bit scan code
//   player_en         - per-player enable
//   act_pulse         - action pulses, bit p*6+a
//   enter_pulse       - pulse for scan code 05A
//   pause_pulse       - pulse for scan code 04D
//   dbg_repeat_state  - repeat FSM states, 2 bits each, {speed,right,left} per player
module keyboard_action_ctrl
    import keyboard_pkg::*;
#(
    parameter int NUM_PLAYERS   = 2,
    parameter int REPEAT_DELAY  = 10_000_000,
    parameter int REPEAT_PERIOD = 2_500_000,
    parameter logic [9*ACTIONS_PER_PLAYER*NUM_PLAYERS-1:0] KEY_MAP =
        (9*ACTIONS_PER_PLAYER*NUM_PLAYERS)'(DEFAULT_KEY_MAP)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [511:0]                         key_down,
    input  logic [NUM_PLAYERS-1:0]               player_en,
    output logic [NUM_PLAYERS*ACTIONS_PER_PLAYER-1:0] act_pulse,
    output logic                                 enter_pulse,
    output logic                                 pause_pulse,
    output logic [NUM_PLAYERS*6-1:0]             dbg_repeat_state
);

    // Edge-only channels: rotate/change/drop per player, then enter, pause.
    localparam int NUM_EDGE   = 3*NUM_PLAYERS + 2;
    localparam int EDGE_ENTER = NUM_EDGE - 2;
    localparam int EDGE_PAUSE = NUM_EDGE - 1;

    logic [NUM_EDGE-1:0] edge_lvl;
    logic [NUM_EDGE-1:0] edge_en;
    logic [NUM_EDGE-1:0] edge_smp;
    logic [NUM_EDGE-1:0] edge_smp_q;
    logic [NUM_EDGE-1:0] edge_pls;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        localparam int BASE = p*ACTIONS_PER_PLAYER;

        logic [ACTIONS_PER_PLAYER-1:0] lvl;
        rpt_state_t left_state, right_state, speed_state;

        // Gating before the sample register makes a re-enable with a key
        // held look like a fresh rise.
        for (genvar a = 0; a < ACTIONS_PER_PLAYER; a++) begin : g_lvl
            assign lvl[a] = key_down[KEY_MAP[9*(BASE+a) +: 9]] & player_en[p];
        end

        assign edge_lvl[3*p+0] = lvl[ACT_ROTATE];
        assign edge_lvl[3*p+1] = lvl[ACT_CHANGE];
        assign edge_lvl[3*p+2] = lvl[ACT_DROP];
        assign edge_en[3*p +: 3] = {3{player_en[p]}};

        assign act_pulse[BASE+ACT_ROTATE] = edge_pls[3*p+0];
        assign act_pulse[BASE+ACT_CHANGE] = edge_pls[3*p+1];
        assign act_pulse[BASE+ACT_DROP]   = edge_pls[3*p+2];

        // Left and right block each other so holding both does nothing.
        key_repeat_fsm #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_left (
            .clk        (clk),
            .rst        (rst),
            .key_level  (lvl[ACT_LEFT]),
            .block_level(lvl[ACT_RIGHT]),
            .enable     (player_en[p]),
            .pulse      (act_pulse[BASE+ACT_LEFT]),
            .state_dbg  (left_state)
        );

        key_repeat_fsm #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_right (
            .clk        (clk),
            .rst        (rst),
            .key_level  (lvl[ACT_RIGHT]),
            .block_level(lvl[ACT_LEFT]),
            .enable     (player_en[p]),
            .pulse      (act_pulse[BASE+ACT_RIGHT]),
            .state_dbg  (right_state)
        );

        key_repeat_fsm #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_speed (
            .clk        (clk),
            .rst        (rst),
            .key_level  (lvl[ACT_SPEED]),
            .block_level(1'b0),
            .enable     (player_en[p]),
            .pulse      (act_pulse[BASE+ACT_SPEED]),
            .state_dbg  (speed_state)
        );

        assign dbg_repeat_state[6*p +: 6] = {speed_state, right_state, left_state};
    end

    assign edge_lvl[EDGE_ENTER] = key_down[CODE_ENTER];
    assign edge_lvl[EDGE_PAUSE] = key_down[CODE_PAUSE];
    assign edge_en[EDGE_ENTER]  = 1'b1;
    assign edge_en[EDGE_PAUSE]  = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_smp   <= '0;
            edge_smp_q <= '0;
            edge_pls   <= '0;
        end else begin
            edge_smp   <= edge_lvl;
            edge_smp_q <= edge_smp;
            edge_pls   <= edge_smp & ~edge_smp_q & edge_en;
        end
    end

    assign enter_pulse = edge_pls[EDGE_ENTER];
    assign pause_pulse = edge_pls[EDGE_PAUSE];

endmodule

// File: tb/tb_keyboard_action_ctrl.sv
// Scoreboard bench for keyboard_action_ctrl (NUM_PLAYERS=2, REPEAT_DELAY=8,
// REPEAT_PERIOD=3). Stimulus pushes each expected pulse (cycle + output
// vector {pause, enter, act}) into exp_q/exp_cyc_q; the monitor pops one
// entry whenever any output pulses and checks all outputs stay 0 in reset.
// Repeat expectations are included only when KEY_AUTOREPEAT_EN is defined.
module tb_keyboard_action_ctrl;

    localparam int NP = 2;
    localparam int RD = 8;
    localparam int RP = 3;
    localparam int OW = NP*6 + 2;

    localparam logic [8:0] K_S   = 9'h01B;  // P1 left
    localparam logic [8:0] K_F   = 9'h02B;  // P1 right
    localparam logic [8:0] K_E   = 9'h024;  // P1 rotate
    localparam logic [8:0] K_D   = 9'h023;  // P1 speed
    localparam logic [8:0] K_1   = 9'h069;  // P2 left
    localparam logic [8:0] K_5   = 9'h073;  // P2 rotate
    localparam logic [8:0] K_ENT = 9'h05A;
    localparam logic [8:0] K_PAU = 9'h04D;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [511:0]         key_down = '0;
    logic [NP-1:0]        player_en = '1;
    logic [NP*6-1:0]      act_pulse;
    logic                 enter_pulse;
    logic                 pause_pulse;
    logic [NP*6-1:0]      dbg_repeat_state;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    logic done = 1'b0;

    logic [OW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic [OW-1:0] mon_obs;
    logic [OW-1:0] mon_exp;
    int            mon_cyc;

    keyboard_action_ctrl #(
        .NUM_PLAYERS  (NP),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .key_down        (key_down),
        .player_en       (player_en),
        .act_pulse       (act_pulse),
        .enter_pulse     (enter_pulse),
        .pause_pulse     (pause_pulse),
        .dbg_repeat_state(dbg_repeat_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=no_end want=end", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_key(input logic [8:0] code, input logic v);
        key_down[code] = v;
    endtask

    function automatic logic [OW-1:0] bit_of(input int i);
        logic [OW-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic expect_at(input int c, input logic [OW-1:0] v);
        exp_cyc_q.push_back(c);
        exp_q.push_back(v);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        mon_obs = {pause_pulse, enter_pulse, act_pulse};
        if (rst) begin
            n_vec++;
            if (mon_obs != '0) begin
                n_err++;
                $display("FAIL reset_quiet cyc=%0d got=%h want=0", cyc, mon_obs);
            end
        end else if (mon_obs != '0) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse cyc=%0d got=%h want=none", cyc, mon_obs);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_cyc = exp_cyc_q.pop_front();
                if (mon_exp != mon_obs || mon_cyc != cyc) begin
                    n_err++;
                    $display("FAIL pulse got=%h@%0d want=%h@%0d", mon_obs, cyc, mon_exp, mon_cyc);
                end
            end
        end
        if (done) begin
            while (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_cyc = exp_cyc_q.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missed_pulse got=none want=%h@%0d", mon_exp, mon_cyc);
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;

        tick(3);
        rst = 1'b0;
        tick(3);

        // Left held 20 cycles: press, then repeats every RP after RD.
        n = cyc;
        set_key(K_S, 1'b1);
        expect_at(n+2, bit_of(0));
`ifdef KEY_AUTOREPEAT_EN
        expect_at(n+10, bit_of(0));
        expect_at(n+13, bit_of(0));
        expect_at(n+16, bit_of(0));
        expect_at(n+19, bit_of(0));
`endif
        tick(20);
        set_key(K_S, 1'b0);
        tick(10);

        // Rotate held 20 cycles: one pulse only.
        n = cyc;
        set_key(K_E, 1'b1);
        expect_at(n+2, bit_of(2));
        tick(20);
        set_key(K_E, 1'b0);
        tick(6);

        // Left+right together: nothing; releasing right gives left a press.
        n = cyc;
        set_key(K_S, 1'b1);
        set_key(K_F, 1'b1);
        tick(5);
        set_key(K_F, 1'b0);
        expect_at(n+7, bit_of(0));
        tick(4);
        set_key(K_S, 1'b0);
        tick(10);

        // P2 disabled with left held, then enabled.
        player_en = 2'b01;
        n = cyc;
        set_key(K_1, 1'b1);
        tick(5);
        player_en = 2'b11;
        expect_at(n+7, bit_of(6));
        tick(3);
        set_key(K_1, 1'b0);
        tick(10);

        // Reset in the middle of a held right key.
        n = cyc;
        set_key(K_F, 1'b1);
        expect_at(n+2, bit_of(1));
        tick(5);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        expect_at(n+9, bit_of(1));
`ifdef KEY_AUTOREPEAT_EN
        expect_at(n+17, bit_of(1));
`endif
        tick(11);
        set_key(K_F, 1'b0);
        tick(10);

        // Speed, P2 rotate and enter pressed together, held 30 cycles.
        n = cyc;
        set_key(K_D, 1'b1);
        set_key(K_5, 1'b1);
        set_key(K_ENT, 1'b1);
        expect_at(n+2, bit_of(4) | bit_of(8) | bit_of(12));
`ifdef KEY_AUTOREPEAT_EN
        for (int k = 10; k <= 31; k += 3) expect_at(n+k, bit_of(4));
`endif
        tick(30);
        set_key(K_D, 1'b0);
        set_key(K_5, 1'b0);
        set_key(K_ENT, 1'b0);
        tick(10);

        // Pause released for one sample then pressed again.
        n = cyc;
        set_key(K_PAU, 1'b1);
        expect_at(n+2, bit_of(13));
        tick(3);
        set_key(K_PAU, 1'b0);
        tick(1);
        set_key(K_PAU, 1'b1);
        expect_at(n+6, bit_of(13));
        tick(3);
        set_key(K_PAU, 1'b0);
        tick(5);

        // Left released for one sample: new press restarts the delay.
        n = cyc;
        set_key(K_S, 1'b1);
        expect_at(n+2, bit_of(0));
        tick(5);
        set_key(K_S, 1'b0);
        tick(1);
        set_key(K_S, 1'b1);
        expect_at(n+8, bit_of(0));
`ifdef KEY_AUTOREPEAT_EN
        expect_at(n+16, bit_of(0));
`endif
        tick(11);
        set_key(K_S, 1'b0);
        tick(10);

        done = 1'b1;
    end

endmodule
